// File: rtl/uc_multicycle_if.sv
// Memory handshake bundle between the multicycle control unit and instruction/data memory.
// A request is held high until the matching ack; an ack seen without a request is ignored.
interface uc_multicycle_if;
   logic i_mem_req;
   logic i_mem_ack;
   logic d_mem_req;
   logic d_mem_ack;
   logic d_mem_we;

   modport master (
      output i_mem_req, d_mem_req, d_mem_we,
      input  i_mem_ack, d_mem_ack
   );

   modport slave (
      input  i_mem_req, d_mem_req, d_mem_we,
      output i_mem_ack, d_mem_ack
   );
endinterface

// File: rtl/uc_multicycle.sv
// Multicycle control unit for an RV32I core: sequences fetch/decode/execute/memory/write-back.
// Optional macro UC_TRAP_EN adds the TRAP state (illegal instruction, memory timeout).
module uc_multicycle #(
   parameter int INSTRET_W   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uc_multicycle_if.master      mem,
   input  logic [31:0]          instr,
   input  logic [3:0]           alu_flags,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic [1:0]           pc_src,
   output logic                 rf_we,
   output logic [1:0]           rf_src,
   output logic                 alu_src_a,
   output logic                 alu_src_b,
   output logic [3:0]           alu_cmd,
   output logic [2:0]           imm_sel,
   output logic [INSTRET_W-1:0] instret,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [3:0]           dbg_state
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EX_ALU, S_EX_ADDR, S_MEM_RD, S_MEM_WR,
      S_EX_BR, S_EX_JAL, S_EX_JALR, S_EX_U, S_WB, S_TRAP
   } state_e;

   state_e                 state_q, state_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   logic [6:0]             opcode;
   logic [2:0]             funct3;
   logic                   funct7_5;
   logic                   br_taken;
   logic [3:0]             op_alu_cmd;
   logic                   illegal;
   logic                   mem_wait;
   logic                   unused_bits;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7_5  = instr[30];
   assign instret   = instret_q;
   assign dbg_state = state_q;

   // Flags come from rs1 - rs2 computed in EX_BR; C=1 means no borrow (rs1 >= rs2 unsigned).
   always_comb begin
      case (funct3)
         3'b000:  br_taken = alu_flags[0];
         3'b001:  br_taken = ~alu_flags[0];
         3'b100:  br_taken = alu_flags[1] ^ alu_flags[2];
         3'b101:  br_taken = ~(alu_flags[1] ^ alu_flags[2]);
         3'b110:  br_taken = ~alu_flags[3];
         3'b111:  br_taken = alu_flags[3];
         default: br_taken = 1'b0;
      endcase
   end

   // funct7[5] means sub only for R-type; for right shifts it means arithmetic in both forms.
   always_comb begin
      case (funct3)
         3'b000:  op_alu_cmd = (opcode == OPC_OP && funct7_5) ? 4'd1 : 4'd0;
         3'b001:  op_alu_cmd = 4'd2;
         3'b010:  op_alu_cmd = 4'd3;
         3'b011:  op_alu_cmd = 4'd4;
         3'b100:  op_alu_cmd = 4'd5;
         3'b101:  op_alu_cmd = funct7_5 ? 4'd7 : 4'd6;
         3'b110:  op_alu_cmd = 4'd8;
         default: op_alu_cmd = 4'd9;
      endcase
   end

`ifdef UC_TRAP_EN
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [1:0]       cause_q, cause_d;
   logic             timeout_hit;

   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == CNT_W'(MEM_TIMEOUT - 1));
   assign trap        = (state_q == S_TRAP);
   assign trap_cause  = cause_q;
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
`else
   assign trap        = 1'b0;
   assign trap_cause  = 2'b00;
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], (MEM_TIMEOUT != 0)};
`endif

   always_comb begin
      state_d       = state_q;
      instret_d     = instret_q;
      mem.i_mem_req = 1'b0;
      mem.d_mem_req = 1'b0;
      mem.d_mem_we  = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 2'd0;
      rf_we         = 1'b0;
      rf_src        = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 1'b0;
      alu_cmd       = 4'd0;
      imm_sel       = 3'd0;
      illegal       = 1'b0;
      mem_wait      = 1'b0;
`ifdef UC_TRAP_EN
      wait_d        = '0;
      cause_d       = cause_q;
`endif
      // While reset is held every output stays at its idle value, so requests drop at once.
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem.i_mem_req = 1'b1;
               if (mem.i_mem_ack) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end else begin
                  mem_wait = 1'b1;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OPC_OP, OPC_OPIMM:   state_d = S_EX_ALU;
                  OPC_LOAD, OPC_STORE: state_d = S_EX_ADDR;
                  OPC_BRANCH:          if (funct3[2:1] == 2'b01) illegal = 1'b1;
                                       else state_d = S_EX_BR;
                  OPC_JAL:             state_d = S_EX_JAL;
                  OPC_JALR:            state_d = S_EX_JALR;
                  OPC_LUI, OPC_AUIPC:  state_d = S_EX_U;
                  default:             illegal = 1'b1;
               endcase
            end
            S_EX_ALU: begin
               alu_cmd   = op_alu_cmd;
               alu_src_b = (opcode == OPC_OPIMM);
               state_d   = S_WB;
            end
            S_EX_ADDR: begin
               alu_src_b = 1'b1;
               imm_sel   = (opcode == OPC_STORE) ? 3'd1 : 3'd0;
               state_d   = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem.d_mem_req = 1'b1;
               rf_src        = 2'd1;
               if (mem.d_mem_ack) state_d = S_WB;
               else mem_wait = 1'b1;
            end
            S_MEM_WR: begin
               mem.d_mem_req = 1'b1;
               mem.d_mem_we  = 1'b1;
               if (mem.d_mem_ack) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mem_wait = 1'b1;
               end
            end
            S_EX_BR: begin
               alu_cmd = 4'd1;
               imm_sel = 3'd2;
               pc_we   = 1'b1;
               pc_src  = br_taken ? 2'd1 : 2'd0;
               state_d = S_FETCH;
            end
            S_EX_JAL: begin
               imm_sel = 3'd4;
               pc_we   = 1'b1;
               pc_src  = 2'd1;
               rf_we   = 1'b1;
               rf_src  = 2'd2;
               state_d = S_FETCH;
            end
            S_EX_JALR: begin
               alu_src_b = 1'b1;
               pc_we     = 1'b1;
               pc_src    = 2'd2;
               rf_we     = 1'b1;
               rf_src    = 2'd2;
               state_d   = S_FETCH;
            end
            S_EX_U: begin
               imm_sel = 3'd3;
               if (opcode == OPC_LUI) begin
                  rf_src = 2'd3;
               end else begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
               end
               state_d = S_WB;
            end
            S_WB: begin
               pc_we   = 1'b1;
               rf_we   = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || (opcode == OPC_LOAD) ||
                         (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
               rf_src  = (opcode == OPC_LOAD) ? 2'd1 : (opcode == OPC_LUI) ? 2'd3 : 2'd0;
               state_d = S_FETCH;
            end
            default: state_d = state_q;
         endcase
      end

`ifdef UC_TRAP_EN
      if (illegal) begin
         state_d = S_TRAP;
         cause_d = 2'd1;
      end
      if (mem_wait) begin
         wait_d = wait_q + CNT_W'(1);
         if (timeout_hit) begin
            state_d = S_TRAP;
            cause_d = (state_q == S_FETCH) ? 2'd2 : 2'd3;
         end
      end
`else
      if (illegal) state_d = S_WB;
`endif

      // pc_we is only ever raised in the final cycle of an instruction.
      if (pc_we) instret_d = instret_q + INSTRET_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

`ifdef UC_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q  <= '0;
         cause_q <= 2'd0;
      end else begin
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end
`endif

endmodule

// File: doc/uc_multicycle.md
# uc_multicycle

Parametrised multicycle control unit for the RV32I processor core. It sequences fetch, decode, execute, memory and write-back for the full RV32I integer subset: R-type, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC. It drives every datapath select, write enable and ALU command. It handshakes with instruction and data memory that have variable latency, resolves branches from ALU flags, and keeps a retired-instruction counter.

## Interface

Parameters:
- INSTRET_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 255: maximum cycles a memory request may wait for ack; 0 means no limit. Used only with UC_TRAP_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- instr  in  32  instruction register contents; stable from the cycle after ir_we.
- alu_flags  in  4  [0] zero, [1] MSB/negative, [2] signed overflow, [3] carry-out (1 = no borrow on subtract).
- i_mem_ack  in  1  instruction read complete.
- d_mem_ack  in  1  data access complete.
- i_mem_req  out  1  instruction read request.
- d_mem_req  out  1  data access request.
- d_mem_we  out  1  data write (store).
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_src  out  2  0 PC+4, 1 PC+imm, 2 ALU result with bit 0 cleared.
- rf_we  out  1  register-file write.
- rf_src  out  2  0 ALU, 1 memory data, 2 PC+4, 3 immediate.
- alu_src_a  out  1  0 rs1, 1 PC.
- alu_src_b  out  1  0 rs2, 1 immediate.
- alu_cmd  out  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
- imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J.
- instret  out  INSTRET_W  retired-instruction count.
- trap  out  1  trap state active (0 without UC_TRAP_EN).
- trap_cause  out  2  1 illegal opcode, 2 instruction-memory timeout, 3 data-memory timeout.

## Operation

- States: FETCH, DECODE, EX_ALU (R and OP-IMM), EX_ADDR (LOAD and STORE), MEM_RD, MEM_WR, EX_BR, EX_JAL, EX_JALR, EX_U, WB, TRAP.
- Outputs are Moore decodes of the state and the instr fields. The exceptions are pc_we/pc_src in EX_BR and the ack-qualified signals, which depend on inputs in the same cycle.
- FETCH:
  - i_mem_req is held at 1 until i_mem_ack.
  - On ack: ir_we=1 and the next state is DECODE.
- DECODE dispatches on instr[6:0]. Unknown opcodes go to TRAP with UC_TRAP_EN; otherwise they retire as a NOP through WB with rf_we=0.
- EX_ALU:
  - alu_cmd is decoded from funct3 and funct7[5]. funct7[5] selects sub only for R-type; for shifts it selects sra.
  - alu_src_b is 0 for R-type and 1 for OP-IMM, with imm_sel=I.
  - Next state is WB.
- EX_ADDR: add with alu_src_b=1; imm_sel is I for LOAD and S for STORE. Next state is MEM_RD or MEM_WR.
- MEM_RD:
  - d_mem_req=1 until d_mem_ack.
  - On ack, go to WB with rf_src=1 latched.
- MEM_WR:
  - d_mem_req=1 and d_mem_we=1 until d_mem_ack.
  - On ack: pc_we=1, pc_src=0, and the instruction retires; next state is FETCH.
- EX_BR:
  - alu_cmd=sub, imm_sel=B, and pc_we=1 unconditionally.
  - pc_src=1 when the branch is taken, else 0. Next state is FETCH.
  - Taken conditions (N = flags[1], V = flags[2], C = flags[3]):
    - beq: zero.
    - bne: !zero.
    - blt: N^V.
    - bge: !(N^V).
    - bltu: !C.
    - bgeu: C.
  - funct3 values 010 and 011 are illegal.
- EX_JAL: imm_sel=J, pc_we=1, pc_src=1, rf_we=1, rf_src=2. Next state is FETCH.
- EX_JALR: alu add with alu_src_b=1, imm_sel=I, pc_we=1, pc_src=2, rf_we=1, rf_src=2. Next state is FETCH.
- EX_U: imm_sel=U.
  - LUI: rf_src=3.
  - AUIPC: alu_src_a=1, alu_src_b=1, add, rf_src=0.
  - Next state is WB.
- WB: rf_we=1 (except for the NOP case), pc_we=1, pc_src=0. Next state is FETCH.
- instret increments by 1 in every cycle in which the instruction retires, i.e. the last cycle with pc_we=1. It wraps modulo 2^INSTRET_W.

## Timing

- Reset values:
  - State is FETCH.
  - All enables and requests are 0.
  - All selects and alu_cmd are 0.
  - instret = 0, trap = 0, trap_cause = 0.
- When rst_n is asserted mid-access, requests drop immediately with no retire.
- Cycles per instruction when ack arrives in the same cycle as the request; each wait cycle adds 1:
  - BRANCH, JAL, JALR: 3.
  - R-type, OP-IMM, LUI, AUIPC, STORE: 4.
  - LOAD: 5.
- Writes to rd=x0 are still issued; the register file ignores them.
- An ack outside a request is ignored.

## Configuration

- UC_TRAP_EN defined:
  - Illegal opcodes and illegal branch funct3 values enter TRAP.
  - A request unacknowledged for MEM_TIMEOUT cycles enters TRAP. The wait counter clears at each new request.
  - In TRAP: trap=1, trap_cause is held, all enables are 0, and the block stays there until reset.
- UC_TRAP_EN undefined: TRAP, the timeout counter and trap_cause are absent; trap is tied to 0; memory waits are unbounded; illegal instructions retire as NOPs.

## Test plan

- add x3,x1,x2 with immediate acks: ir_we in cycle 1, alu_cmd=0 and alu_src_b=0 in cycle 3, rf_we=1 and pc_we=1 in cycle 4, instret 0→1.
- lw with 3 wait cycles on d_mem_ack: d_mem_req held 4 cycles, then WB with rf_src=1; total 8 cycles.
- bltu with flags C=0 gives pc_src=1; C=1 gives pc_src=0. bge with N=1, V=1 is taken.
- jalr: pc_src=2, rf_src=2, rf_we=1 in cycle 3; next cycle is FETCH.
- With UC_TRAP_EN and MEM_TIMEOUT=4: i_mem_ack never asserted gives trap=1 and trap_cause=2 after 4 request cycles. Opcode 0x7F gives trap_cause=1.
- rst_n low during MEM_WR wait: d_mem_req=0 asynchronously, state FETCH, instret=0.
